// File: rtl/core_pipe_sched_pkg.sv
// Shared encodings for the pipeline-control scheduler: hold levels, FSM states
// and the core-wide enable/bus-width constants.
package core_pipe_sched_pkg;

    localparam int MemAddressBus = 32;

    localparam logic JumpEnable = 1'b1;
    localparam logic HoldEnable = 1'b1;

    localparam logic [2:0] HoldNone = 3'd0;
    localparam logic [2:0] HoldPc   = 3'd1;
    localparam logic [2:0] HoldIf   = 3'd2;
    localparam logic [2:0] HoldId   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_INT_WAIT  = 2'd2,
        ST_INT_ENTER = 2'd3
    } sched_state_t;

    function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_pipe_sched_cnt.sv
// Loadable down-counter with enable; stops at zero. Holds the post-redirect
// flush length.
module core_pipe_sched_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/core_pipe_sched.sv
// Pipeline-control scheduler: merges ex jump/hold, bus stall and interrupt
// entry into one redirect port and one hold level, with a post-redirect flush.
//
// state        | meaning
// ST_IDLE      | pass-through, no pending work
// ST_FLUSH     | IF/ID bubbles after a redirect, counted by flush_cnt
// ST_INT_WAIT  | interrupt pending, draining execute
// ST_INT_ENTER | one cycle: redirect to captured vector, ack to clint
module core_pipe_sched
    import core_pipe_sched_pkg::*;
#(
    parameter int ADDR_W       = MemAddressBus,
    parameter int FLUSH_CYCLES = 2,
    parameter int INT_WAIT_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_in,
    input  logic [ADDR_W-1:0] jump_addr_in,
    input  logic              hold_flag_ex_in,
    input  logic              hold_req_bus_in,
    input  logic              int_req_in,
    input  logic [ADDR_W-1:0] int_addr_in,
    output logic              jump_flag_out,
    output logic [ADDR_W-1:0] jump_addr_out,
    output logic [2:0]        hold_flag_out,
    output logic              flush_if_out,
    output logic              int_ack_out,
    output logic              int_timeout_err_out,
    output logic              busy_out
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [7:0] WAIT_LAST  = 8'(INT_WAIT_MAX - 1);

    sched_state_t      r_state;
    logic [7:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_int_addr;
    logic              r_err;

    logic              w_in_enter;
    logic              w_in_wait;
    logic              w_jump_flag;
    logic [2:0]        w_hold_hi;
    logic [2:0]        w_hold_lo;
    logic [2:0]        w_hold;
    logic              w_cnt_load;
    logic              w_cnt_en;
    logic [3:0]        w_flush_cnt;
    logic              w_flush_done;
    logic              w_wait_hit;

    assign w_in_enter  = (r_state == ST_INT_ENTER);
    assign w_in_wait   = (r_state == ST_INT_WAIT);
    assign w_jump_flag = w_in_enter ? JumpEnable : jump_flag_in;

    assign w_hold_hi = ((w_jump_flag == JumpEnable) || (hold_flag_ex_in == HoldEnable) ||
                        w_in_wait || w_in_enter) ? HoldId : HoldNone;
    assign w_hold_lo = hold_req_bus_in ? HoldPc : HoldNone;
    assign w_hold    = hold_max(w_hold_hi, w_hold_lo);

    // Combinational term lets the error show on the very cycle the limit is hit.
    assign w_wait_hit = w_in_wait && (r_wait_cnt >= WAIT_LAST);

    assign w_flush_done = (r_state == ST_FLUSH) && !jump_flag_in && !hold_req_bus_in &&
                          (w_flush_cnt <= 4'd1);

    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;
        case (r_state)
            ST_IDLE:      w_cnt_load = !int_req_in && jump_flag_in;
            ST_FLUSH: begin
                w_cnt_load = jump_flag_in;
                w_cnt_en   = !jump_flag_in && !hold_req_bus_in;
            end
            ST_INT_ENTER: w_cnt_load = 1'b1;
            default: ;
        endcase
    end

    core_pipe_sched_cnt #(
        .CNT_W(4)
    ) u_flush_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (FLUSH_LOAD),
        .i_en       (w_cnt_en),
        .o_cnt      (w_flush_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_int_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_wait_hit) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (int_req_in) begin
                        r_state    <= ST_INT_WAIT;
                        r_int_addr <= int_addr_in;
                        r_wait_cnt <= '0;
                    end else if (jump_flag_in) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_done) begin
                        if (int_req_in) begin
                            r_state    <= ST_INT_WAIT;
                            r_int_addr <= int_addr_in;
                            r_wait_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_INT_WAIT: begin
                    if (r_wait_cnt != 8'hFF) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                    if (!hold_flag_ex_in && !jump_flag_in) begin
                        r_state <= ST_INT_ENTER;
                    end
                end
                ST_INT_ENTER: r_state <= ST_FLUSH;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    assign jump_flag_out       = w_jump_flag;
    assign jump_addr_out       = w_in_enter ? r_int_addr :
                                 (jump_flag_in ? jump_addr_in : '0);
    assign hold_flag_out       = w_hold;
    assign flush_if_out        = (r_state == ST_FLUSH) && (w_hold < HoldIf);
    assign int_ack_out         = w_in_enter;
    assign int_timeout_err_out = r_err || w_wait_hit;
    assign busy_out            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_core_pipe_sched.sv
// Directed bench for core_pipe_sched: jump flush, bus-stall stretch, interrupt
// drain/entry, drain timeout and reset during a pending interrupt.
module tb_core_pipe_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_in;
    logic [31:0] jump_addr_in;
    logic        hold_flag_ex_in;
    logic        hold_req_bus_in;
    logic        int_req_in;
    logic [31:0] int_addr_in;

    logic        jump_flag_out,   t_jump_flag_out;
    logic [31:0] jump_addr_out,   t_jump_addr_out;
    logic [2:0]  hold_flag_out,   t_hold_flag_out;
    logic        flush_if_out,    t_flush_if_out;
    logic        int_ack_out,     t_int_ack_out;
    logic        int_timeout_err_out, t_int_timeout_err_out;
    logic        busy_out,        t_busy_out;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    core_pipe_sched #(.ADDR_W(32), .FLUSH_CYCLES(2), .INT_WAIT_MAX(64)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in),
        .hold_flag_ex_in(hold_flag_ex_in), .hold_req_bus_in(hold_req_bus_in),
        .int_req_in(int_req_in), .int_addr_in(int_addr_in),
        .jump_flag_out(jump_flag_out), .jump_addr_out(jump_addr_out),
        .hold_flag_out(hold_flag_out), .flush_if_out(flush_if_out),
        .int_ack_out(int_ack_out), .int_timeout_err_out(int_timeout_err_out),
        .busy_out(busy_out)
    );

    // Second instance with a short drain limit for the timeout case.
    core_pipe_sched #(.ADDR_W(32), .FLUSH_CYCLES(2), .INT_WAIT_MAX(4)) dut_t (
        .clk(clk), .rst(rst),
        .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in),
        .hold_flag_ex_in(hold_flag_ex_in), .hold_req_bus_in(hold_req_bus_in),
        .int_req_in(int_req_in), .int_addr_in(int_addr_in),
        .jump_flag_out(t_jump_flag_out), .jump_addr_out(t_jump_addr_out),
        .hold_flag_out(t_hold_flag_out), .flush_if_out(t_flush_if_out),
        .int_ack_out(t_int_ack_out), .int_timeout_err_out(t_int_timeout_err_out),
        .busy_out(t_busy_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // {jump_flag, jump_addr, hold, flush_if, int_ack, timeout_err, busy}
    function automatic logic [63:0] pk(input logic jf, input logic [31:0] ja, input logic [2:0] h,
                                       input logic fl, input logic ack, input logic err,
                                       input logic busy);
        return {24'd0, jf, ja, h, fl, ack, err, busy};
    endfunction

    task automatic drv(input logic jf, input logic [31:0] ja, input logic hex,
                       input logic bus, input logic ireq, input logic [31:0] iaddr);
        jump_flag_in    = jf;
        jump_addr_in    = ja;
        hold_flag_ex_in = hex;
        hold_req_bus_in = bus;
        int_req_in      = ireq;
        int_addr_in     = iaddr;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle's outputs, then advance one clock.
    task automatic step(input string tag, input logic [63:0] exp);
        #1;
        check(tag, pk(jump_flag_out, jump_addr_out, hold_flag_out, flush_if_out,
                      int_ack_out, int_timeout_err_out, busy_out), exp);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    localparam logic [63:0] ZERO = 64'd0;

    initial begin
        rst = 1'b1;
        idle();
        do_reset();

        // Idle after reset: everything quiet.
        for (int i = 0; i < 10; i++) step($sformatf("idle_%0d", i), ZERO);

        // Plain jump and two flush bubbles.
        drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        step("jmp_issue", pk(1, 32'h100, 3, 0, 0, 0, 0));
        idle();
        step("jmp_fl1", pk(0, 0, 0, 1, 0, 0, 1));
        step("jmp_fl2", pk(0, 0, 0, 1, 0, 0, 1));
        step("jmp_idle", ZERO);

        // Bus stall in first flush cycle stretches the flush by one.
        drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        step("bus_issue", pk(1, 32'h100, 3, 0, 0, 0, 0));
        drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step("bus_stall", pk(0, 0, 1, 1, 0, 0, 1));
        idle();
        step("bus_fl2", pk(0, 0, 0, 1, 0, 0, 1));
        step("bus_fl3", pk(0, 0, 0, 1, 0, 0, 1));
        step("bus_idle", ZERO);

        // Jump during flush reloads the counter.
        drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        step("rl_issue", pk(1, 32'h100, 3, 0, 0, 0, 0));
        drv(1'b1, 32'h120, 1'b0, 1'b0, 1'b0, 32'h0);
        step("rl_jump2", pk(1, 32'h120, 3, 0, 0, 0, 1));
        idle();
        step("rl_fl1", pk(0, 0, 0, 1, 0, 0, 1));
        step("rl_fl2", pk(0, 0, 0, 1, 0, 0, 1));
        step("rl_idle", ZERO);

        // Interrupt with execute busy for four cycles.
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80);
        step("int_req", pk(0, 0, 3, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) step($sformatf("int_drain_%0d", i), pk(0, 0, 3, 0, 0, 0, 1));
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80);
        step("int_wait_last", pk(0, 0, 3, 0, 0, 0, 1));
        step("int_enter", pk(1, 32'h80, 3, 0, 1, 0, 1));
        idle();
        step("int_fl1", pk(0, 0, 0, 1, 0, 0, 1));
        step("int_fl2", pk(0, 0, 0, 1, 0, 0, 1));
        step("int_idle", ZERO);

        // Drain timeout on the short-limit instance.
        do_reset();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200);
        tick();
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("tmo_wait_%0d", i), {63'd0, t_int_timeout_err_out}, {63'd0, (i == 4)});
            tick();
        end
        #1;
        check("tmo_held", {63'd0, t_int_timeout_err_out}, 64'd1);
        check("tmo_main_clear", {63'd0, int_timeout_err_out}, 64'd0);
        drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
        tick();
        #1;
        check("tmo_enter", {30'd0, t_int_ack_out, t_jump_flag_out, t_jump_addr_out}, {30'd0, 2'b11, 32'h200});
        idle();
        tick();
        tick();
        tick();
        #1;
        check("tmo_sticky", {62'd0, t_busy_out, t_int_timeout_err_out}, 64'd1);
        do_reset();
        #1;
        check("tmo_after_rst", {62'd0, t_busy_out, t_int_timeout_err_out}, 64'd0);

        // Simultaneous interrupt and jump, jump during drain, then reset mid-drain.
        drv(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h300);
        step("sim_issue", pk(1, 32'h40, 3, 0, 0, 0, 0));
        drv(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h300);
        step("sim_wait_jmp", pk(1, 32'h44, 3, 0, 0, 0, 1));
        idle();
        rst = 1'b1;
        step("sim_rst_cycle", pk(0, 0, 3, 0, 0, 0, 1));
        rst = 1'b0;
        step("sim_post_rst", ZERO);
        step("sim_quiet", ZERO);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
